// File: rtl/present_iter_core.sv
// Iterative PRESENT-80/128 encryption core: one 64-bit block is in flight at a time.
// UNROLL rounds run per clock, and each round has its own key-schedule step.
module present_iter_core #(
  parameter int KEY_LEN = 80,
  parameter int UNROLL  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [63:0]        data_i,
  input  logic [KEY_LEN-1:0] key_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [63:0]        data_o,
  output logic               busy_o
);

  if (KEY_LEN != 80 && KEY_LEN != 128) begin : g_bad_key_len
    $error("present_iter_core: KEY_LEN must be 80 or 128");
  end
  if (UNROLL < 1 || UNROLL > 31) begin : g_bad_unroll
    $error("present_iter_core: UNROLL must be in 1..31");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [5:0]         rc;
  logic [63:0]        st_q;
  logic [KEY_LEN-1:0] key_q;
  logic [63:0]        st_fin;
  logic [KEY_LEN-1:0] key_fin;
  logic               last;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Substitution layer followed by the bit permutation: bit i moves to (16*i) mod 63.
  function automatic logic [63:0] sp_layer(input logic [63:0] x);
    logic [63:0] s;
    logic [63:0] p;
    for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox(x[4*i +: 4]);
    p = '0;
    for (int i = 0; i < 63; i++) p[(i * 16) % 63] = s[i];
    p[63] = s[63];
    return p;
  endfunction

  // Stage j applies round rc+j; stages past round 31 pass state and key through.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [63:0]        st_in, st_out, sp;
    logic [KEY_LEN-1:0] ky_in, ky_out, nk;
    logic [6:0]         rn;
    logic               act;

    if (j == 0) begin : g_first
      assign st_in = st_q;
      assign ky_in = key_q;
    end else begin : g_next
      assign st_in = g_rnd[j-1].st_out;
      assign ky_in = g_rnd[j-1].ky_out;
    end

    assign rn  = {1'b0, rc} + 7'(j);
    assign act = (rn <= 7'd31);
    assign sp  = sp_layer(st_in ^ ky_in[KEY_LEN-1 -: 64]);

    if (KEY_LEN == 80) begin : g_ks80
      logic [79:0] rot;
      assign rot = {ky_in[18:0], ky_in[79:19]};
      assign nk  = {sbox(rot[79:76]), rot[75:20], rot[19:15] ^ rn[4:0], rot[14:0]};
    end else begin : g_ks128
      logic [127:0] rot;
      assign rot = {ky_in[66:0], ky_in[127:67]};
      assign nk  = {sbox(rot[127:124]), sbox(rot[123:120]), rot[119:67],
                    rot[66:62] ^ rn[4:0], rot[61:0]};
    end

    assign st_out = act ? sp : st_in;
    assign ky_out = act ? nk : ky_in;
  end

  assign st_fin  = g_rnd[UNROLL-1].st_out;
  assign key_fin = g_rnd[UNROLL-1].ky_out;
  assign last    = ({1'b0, rc} + 7'(UNROLL)) > 7'd31;

  // Valid/ready: a transfer happens on any edge where valid and ready are both high.
  // Upstream keeps data_i/key_i stable while in_valid_i waits. data_o holds until out_ready_i.
  // In DONE, in_ready_o follows out_ready_i so a new pair can load on the drain edge.
  assign in_ready_o = (state == IDLE) || ((state == DONE) && out_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rc          <= 6'd1;
      st_q        <= '0;
      key_q       <= '0;
      data_o      <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            st_q   <= data_i;
            key_q  <= key_i;
            rc     <= 6'd1;
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            data_o      <= st_fin ^ key_fin[KEY_LEN-1 -: 64];
            out_valid_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= DONE;
          end else begin
            st_q  <= st_fin;
            key_q <= key_fin;
            rc    <= rc + 6'(UNROLL);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            if (in_valid_i) begin
              st_q   <= data_i;
              key_q  <= key_i;
              rc     <= 6'd1;
              busy_o <= 1'b1;
              state  <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_iter_core.sv
// Bench for present_iter_core: six instances cover KEY_LEN 80/128 and several UNROLL values.
// Known-answer vectors, latency, backpressure and mid-run reset are all checked.
module tb_present_iter_core;

  function automatic int un_of(input int i);
    case (i)
      0: return 1;  1: return 2;  2: return 4;
      3: return 5;  4: return 31; default: return 1;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0: return 31; 1: return 16; 2: return 8;
      3: return 7;  4: return 1;  default: return 31;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]   in_valid;
  logic [5:0]   out_ready;
  logic [63:0]  data;
  logic [79:0]  key80;
  logic [127:0] key128;
  wire  [5:0]   in_ready;
  wire  [5:0]   out_valid;
  wire  [5:0]   busy;
  wire  [63:0]  dout [6];

  for (genvar g = 0; g < 6; g++) begin : g_dut
    if (g == 5) begin : g_k128
      present_iter_core #(.KEY_LEN(128), .UNROLL(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
        .data_i(data), .key_i(key128),
        .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
        .data_o(dout[g]), .busy_o(busy[g]));
    end else begin : g_k80
      present_iter_core #(.KEY_LEN(80), .UNROLL(un_of(g))) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
        .data_i(data), .key_i(key80),
        .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
        .data_o(dout[g]), .busy_o(busy[g]));
    end
  end

  typedef struct {
    int          inst;
    logic [63:0] ct;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: on each rising out_valid, pop this instance's oldest entry; check data and latency.
  logic [5:0] ov_prev = '0;
  always @(negedge clk) begin
    int k;
    if (rst) begin
      ov_prev = '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (out_valid[i] && !ov_prev[i]) begin
          k = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (k < 0 && exp_q[j].inst == i) k = j;
          if (k < 0) begin
            n_chk++;
            $display("FAIL unexpected_output inst%0d: got %h, expected no output", i, dout[i]);
          end else begin
            check64($sformatf("ciphertext inst%0d", i), dout[i], exp_q[k].ct);
            check_int($sformatf("latency inst%0d", i), cyc, exp_q[k].due);
            exp_q.delete(k);
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic launch(input logic [5:0] mask, input logic [63:0] ct);
    @(negedge clk);
    in_valid = mask;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) begin
        exp_q.push_back('{inst: i, ct: ct, due: cyc + lat_of(i)});
        check1($sformatf("busy_after_accept inst%0d", i), busy[i], 1'b1);
        check1($sformatf("in_ready_in_run inst%0d", i), in_ready[i], 1'b0);
      end
    end
    in_valid = '0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 6; i++) begin
      check1($sformatf("%s in_ready inst%0d", tag, i), in_ready[i], 1'b1);
      check1($sformatf("%s busy inst%0d", tag, i), busy[i], 1'b0);
      check1($sformatf("%s out_valid inst%0d", tag, i), out_valid[i], 1'b0);
    end
  endtask

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] key;
    logic         k128;
    logic [63:0]  ct;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic seen;
    int   b;

    vt[0] = '{pt: 64'h0,                 key: 128'h0,                    k128: 1'b0, ct: 64'h5579C1387B228445};
    vt[1] = '{pt: 64'h0,                 key: {48'h0, {80{1'b1}}},       k128: 1'b0, ct: 64'hE72C46C0F5945049};
    vt[2] = '{pt: 64'hFFFFFFFFFFFFFFFF,  key: 128'h0,                    k128: 1'b0, ct: 64'hA112FFC72F68417B};
    vt[3] = '{pt: 64'hFFFFFFFFFFFFFFFF,  key: {48'h0, {80{1'b1}}},       k128: 1'b0, ct: 64'h3333DCD3213210D2};
    vt[4] = '{pt: 64'h0,                 key: 128'h0,                    k128: 1'b1, ct: 64'h96DB702A2E6900AF};

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    data      = '0;
    key80     = '0;
    key128    = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) check64($sformatf("reset data_o inst%0d", i), dout[i], 64'h0);
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors: 80-bit ones go to every 80-bit instance at once.
    for (int v = 0; v < 5; v++) begin
      data   = vt[v].pt;
      key80  = vt[v].key[79:0];
      key128 = vt[v].key;
      launch(vt[v].k128 ? 6'b100000 : 6'b011111, vt[v].ct);
      drain();
      check_idle($sformatf("after_vec%0d", v));
    end

    // Backpressure on the UNROLL=4 instance.
    out_ready[2] = 1'b0;
    data  = 64'h0;
    key80 = 80'h0;
    launch(6'b000100, 64'h5579C1387B228445);
    b = 0;
    while (!out_valid[2] && b < 50) begin
      @(negedge clk);
      b++;
    end
    check1("bp_out_valid_seen", out_valid[2], 1'b1);
    data        = 64'hFFFFFFFFFFFFFFFF;
    in_valid[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check64($sformatf("bp_hold_data c%0d", c), dout[2], 64'h5579C1387B228445);
      check1($sformatf("bp_hold_valid c%0d", c), out_valid[2], 1'b1);
      check1($sformatf("bp_in_ready c%0d", c), in_ready[2], 1'b0);
      check1($sformatf("bp_not_busy c%0d", c), busy[2], 1'b0);
    end
    out_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{inst: 2, ct: 64'hA112FFC72F68417B, due: cyc + 8});
    check1("bp_busy_after_reload", busy[2], 1'b1);
    check1("bp_valid_dropped", out_valid[2], 1'b0);
    in_valid = '0;
    drain();
    check_idle("after_bp");

    // Reset on the 10th RUN cycle of the UNROLL=1 instance.
    data  = 64'hFFFFFFFFFFFFFFFF;
    key80 = '1;
    launch(6'b000001, 64'h3333DCD3213210D2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("midrst in_ready", in_ready[0], 1'b1);
    check1("midrst out_valid", out_valid[0], 1'b0);
    check1("midrst busy", busy[0], 1'b0);
    check64("midrst data_o", dout[0], 64'h0);
    exp_q.delete();
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check1("aborted_block_absent", seen, 1'b0);
    data  = 64'h0;
    key80 = 80'h0;
    launch(6'b000001, 64'h5579C1387B228445);
    drain();
    check_idle("after_reset_test");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
